d_cache_mem_bridge: RTL

- Memory-side responder for the L1 data cache controller. The controller runs the IDLE/CHK/WHIT/WMISS/RMISS flow and initiates one request at a time; this block completes that request as an AXI4 master transaction.
- A read miss becomes one INCR line-fill burst.
- A write (write-through hit or write miss) becomes one single-beat strobed write.
- Sits between the D-cache and the CPU-side AXI master wrapper. The wrapper ties off ID (4'b0001), SIZE (3'b010) and BURST (INCR).

---
 rtl/d_cache_mem_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/d_cache_mem_bridge.sv
// d_cache_mem_bridge
// Memory-side responder for the L1 data cache. Turns one cache request at a
// time into an AXI4 master transaction: a line read becomes one INCR burst of
// LINE_WORDS beats, a write becomes one single-beat strobed write.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   D_req/D_addr/D_write/D_in/D_type   cache request (sampled in IDLE only)
//   D_out                filled line, word i at [32i+:32]
//   D_wait               request in progress (combinational, stalls same cycle)
//   D_err                one-cycle pulse at completion on SLVERR/DECERR
//   AR*/R*               read address / read data channels
//   AW*/W*/B*            write address / write data / write response channels
module d_cache_mem_bridge #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      D_req,
  input  logic [31:0]               D_addr,
  input  logic                      D_write,
  input  logic [31:0]               D_in,
  input  logic [2:0]                D_type,
  output logic [32*LINE_WORDS-1:0]  D_out,
  output logic                      D_wait,
  output logic                      D_err,
  output logic [31:0]               ARADDR,
  output logic [3:0]                ARLEN,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [31:0]               RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [31:0]               AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [31:0]               WDATA,
  output logic [3:0]                WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY
);

  localparam int unsigned CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_RADDR = 5'b00010,
    S_RDATA = 5'b00100,
    S_WREQ  = 5'b01000,
    S_WRESP = 5'b10000
  } state_e;

  state_e                    state_q;
  logic [31:0]               addr_q;
  logic [31:0]               din_q;
  logic [1:0]                type_q;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [32*LINE_WORDS-1:0]  dout_q;
  logic                      err_q;
  logic                      err_acc_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      aw_done_d;
  logic                      w_done_d;
  logic [3:0]                wstrb;
  logic [31:0]               wdata;
  logic                      unused_ok;

  // Only the error bit of the responses and the size bits of D_type matter.
  assign unused_ok = ^{D_type[2], RRESP[0], BRESP[0]};

  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & AWREADY);
    w_done_d  = w_done_q  | (wvalid_q  & WREADY);
    cnt_d     = (cnt_q == CW'(LINE_WORDS - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    wstrb = 4'b1111;
    wdata = din_q;
    unique case (type_q)
      2'b00: begin
        wstrb = 4'b0001 << addr_q[1:0];
        wdata = {4{din_q[7:0]}};
      end
      2'b01: begin
        wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din_q[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = din_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      type_q    <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
      err_acc_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (D_req) begin
            addr_q    <= D_addr;
            din_q     <= D_in;
            type_q    <= D_type[1:0];
            err_acc_q <= 1'b0;
            if (D_write) begin
              state_q   <= S_WREQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= S_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_RADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (RVALID) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
              if (cnt_q == CW'(i)) dout_q[32*i +: 32] <= RDATA;
            end
            cnt_q <= cnt_d;
            // Completion is decided by RLAST alone, never by the beat count.
            if (RLAST) begin
              state_q   <= S_IDLE;
              rready_q  <= 1'b0;
              err_q     <= err_acc_q | RRESP[1];
              err_acc_q <= 1'b0;
            end else begin
              err_acc_q <= err_acc_q | RRESP[1];
            end
          end
        end
        S_WREQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            state_q  <= S_WRESP;
            bready_q <= 1'b1;
          end
        end
        S_WRESP: begin
          if (BVALID) begin
            state_q  <= S_IDLE;
            bready_q <= 1'b0;
            err_q    <= BRESP[1];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign D_wait  = (state_q != S_IDLE) | D_req;
  assign D_out   = dout_q;
  assign D_err   = err_q;
  assign ARADDR  = {addr_q[31:4], 4'b0000};
  assign ARLEN   = 4'(LINE_WORDS - 1);
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign AWADDR  = {addr_q[31:2], 2'b00};
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata;
  assign WSTRB   = wstrb;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

endmodule
